// File: rtl/maze_view_scanner_if.sv
// Cell stream from the view scanner to the renderer/serialiser: valid/ready
// handshake carrying the cell word, its view coordinates and an end-of-frame mark.
interface maze_view_scanner_if #(
    parameter int SIZE   = 22,
    parameter int CELL_W = 2
);
    localparam int CW = $clog2(SIZE);

    logic              out_valid;
    logic              out_ready;
    logic [CELL_W-1:0] out_cell;
    logic [CW-1:0]     out_x;
    logic [CW-1:0]     out_y;
    logic              out_last;

    modport master (
        output out_valid,
        output out_cell,
        output out_x,
        output out_y,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_cell,
        input  out_x,
        input  out_y,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/maze_view_scanner.sv
// Raster-scan sequencer: sweeps view (x,y), reads maze cells via the rotator index
// and streams them in view order. Optional abort input: MAZE_VIEW_SCANNER_ABORT_EN.
module maze_view_scanner #(
    parameter  int SIZE   = 22,
    parameter  int CELL_W = 2,
    localparam int CW     = $clog2(SIZE),
    localparam int IW     = $clog2(SIZE * SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        direction,
`ifdef MAZE_VIEW_SCANNER_ABORT_EN
    input  logic              abort,
`endif
    output logic [CW-1:0]     rot_x,
    output logic [CW-1:0]     rot_y,
    output logic [1:0]        rot_dir,
    input  logic [IW-1:0]     rot_index,
    output logic              mem_rd_en,
    output logic [IW-1:0]     mem_addr,
    input  logic [CELL_W-1:0] mem_rdata,
    maze_view_scanner_if.master out_if,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_C   = CW'(SIZE - 1);
    localparam int            ENTRY_W = CELL_W + 2 * CW + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [1:0]    dir_q, dir_d;
    logic          done_q, done_d;

    // Tag travelling with the outstanding read; mem_rdata has no sideband of its own.
    logic          infl_q, infl_d;
    logic [CW-1:0] infl_x_q, infl_x_d;
    logic [CW-1:0] infl_y_q, infl_y_d;
    logic          infl_last_q, infl_last_d;

    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;

    logic                    abort_w;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    last_issue;
    logic [1:0]              occ;
    logic [1:0][ENTRY_W-1:0] entry_w;
    logic [ENTRY_W-1:0]      head;
    logic                    head_last;

`ifdef MAZE_VIEW_SCANNER_ABORT_EN
    assign abort_w = abort && (state_q != IDLE);
`else
    assign abort_w = 1'b0;
`endif

    assign head      = entry_w[rd_ptr_q];
    assign head_last = head[ENTRY_W-1];
    assign push      = infl_q;
    assign pop       = (count_q != 2'd0) && out_if.out_ready;
    assign last_issue = (x_q == MAX_C) && (y_q == MAX_C);

    // Occupancy after this cycle's pop, so a streaming consumer sustains one cell per clock.
    assign occ   = count_q + {1'b0, infl_q} - {1'b0, pop};
    assign issue = (state_q == SCAN) && !abort_w && (occ < 2'd2);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        infl_d      = issue;
        infl_x_d    = issue ? x_q : infl_x_q;
        infl_y_d    = issue ? y_q : infl_y_q;
        infl_last_d = issue ? last_issue : infl_last_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = pop  ? ~rd_ptr_q : rd_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    dir_d   = direction;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (last_issue) begin
                        state_d = DRAIN;
                    end else if (x_q == MAX_C) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_w) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            infl_d   = 1'b0;
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            dir_q       <= '0;
            done_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_x_q    <= '0;
            infl_y_q    <= '0;
            infl_last_q <= 1'b0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            infl_q      <= infl_d;
            infl_x_q    <= infl_x_d;
            infl_y_q    <= infl_y_d;
            infl_last_q <= infl_last_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Two-entry FIFO; each slot is {last, y, x, cell}.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] entry_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    entry_q <= {infl_last_q, infl_y_q, infl_x_q, mem_rdata};
                end
            end
            assign entry_w[gi] = entry_q;
        end
    endgenerate

    assign rot_x     = x_q;
    assign rot_y     = y_q;
    assign rot_dir   = dir_q;
    assign mem_rd_en = issue;
    assign mem_addr  = issue ? rot_index : '0;

    assign out_if.out_valid = (count_q != 2'd0);
    assign out_if.out_cell  = head[CELL_W-1:0];
    assign out_if.out_x     = head[CELL_W +: CW];
    assign out_if.out_y     = head[CELL_W+CW +: CW];
    assign out_if.out_last  = (count_q != 2'd0) && head_last;

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
